// File: rtl/line_buf_ctrl.sv
// Sequencer that turns one FIFO_ASYNCH into a one-row line delay for a raster stream.
// Optional build macro LINE_BUF_CTRL_FLUSH_EN adds a FLUSH state that reads out the last stored row.
module line_buf_ctrl #(
    parameter int IMG_WIDTH = 10,
    parameter int NUM_ROWS  = 10,
    parameter int CNT_WIDTH = 4,
    parameter int ROW_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 fifo_wr_en,
    output logic                 fifo_wr_inc,
    output logic                 fifo_rd_en,
    output logic                 fifo_rd_inc,
    output logic                 fifo_wr_clr,
    output logic                 fifo_rd_clr,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] col_cnt,
    output logic [ROW_WIDTH-1:0] row_cnt,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        STREAM  = 3'd2,
        ROW_CLR = 3'd3,
        DONE    = 3'd4
`ifdef LINE_BUF_CTRL_FLUSH_EN
        , FLUSH = 3'd5
`endif
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   col_reg, col_next;
    logic [ROW_WIDTH-1:0]   row_reg, row_next;
    logic                   clr_reg, clr_next;
    logic                   out_valid_reg;
    logic                   accept;
    logic                   last_col;
    logic                   last_row;
    logic                   rd;
    logic                   wr;

    assign pix_ready = (state_reg == FILL) || (state_reg == STREAM);
    assign accept    = pix_valid && pix_ready;
    assign last_col  = (col_reg == CNT_WIDTH'(IMG_WIDTH - 1));
    assign last_row  = (row_reg == ROW_WIDTH'(NUM_ROWS - 1));

`ifdef LINE_BUF_CTRL_FLUSH_EN
    logic [CNT_WIDTH-1:0] flush_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flush_reg <= '0;
        else if (state_reg == FLUSH)
            flush_reg <= flush_reg + 1'b1;
        else
            flush_reg <= '0;
    end
`endif

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        wr         = 1'b0;
        rd         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = FILL;
            end
            FILL, STREAM: begin
                wr = accept;
                rd = accept && (state_reg == STREAM);
                if (accept) begin
                    if (last_col) begin
                        col_next = '0;
                        row_next = row_reg + 1'b1;
`ifdef LINE_BUF_CTRL_FLUSH_EN
                        // the last row still gets a pointer clear so FLUSH reads from address 0
                        state_next = ROW_CLR;
`else
                        state_next = last_row ? DONE : ROW_CLR;
`endif
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            ROW_CLR: begin
`ifdef LINE_BUF_CTRL_FLUSH_EN
                state_next = (row_reg == ROW_WIDTH'(NUM_ROWS)) ? FLUSH : STREAM;
`else
                state_next = STREAM;
`endif
            end
`ifdef LINE_BUF_CTRL_FLUSH_EN
            FLUSH: begin
                rd = 1'b1;
                if (flush_reg == CNT_WIDTH'(IMG_WIDTH - 1))
                    state_next = DONE;
            end
`endif
            DONE: begin
                state_next = IDLE;
                row_next   = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    // clears are registered, so they follow the state being entered
    always_comb begin
        clr_next = (state_next == IDLE) || (state_next == ROW_CLR) || (state_next == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            col_reg       <= '0;
            row_reg       <= '0;
            clr_reg       <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            clr_reg       <= clr_next;
            out_valid_reg <= rd;
        end
    end

    assign fifo_wr_en  = wr;
    assign fifo_wr_inc = wr;
    assign fifo_rd_en  = rd;
    assign fifo_rd_inc = rd;
    assign fifo_wr_clr = clr_reg;
    assign fifo_rd_clr = clr_reg;
    assign out_valid   = out_valid_reg;
    assign col_cnt     = col_reg;
    assign row_cnt     = row_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl with a behavioural FIFO and a pixel scoreboard.
module tb_line_buf_ctrl;
    localparam int W  = 4;
    localparam int R  = 3;
    localparam int CW = 3;
    localparam int RW = 2;
`ifdef LINE_BUF_CTRL_FLUSH_EN
    localparam int FLUSH = 1;
`else
    localparam int FLUSH = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, pix_valid;
    logic          pix_ready, fifo_wr_en, fifo_wr_inc, fifo_rd_en, fifo_rd_inc;
    logic          fifo_wr_clr, fifo_rd_clr, out_valid, busy, done;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;

    logic [7:0] pix_data;
    logic [7:0] mem [0:7];
    logic [2:0] wptr, rptr;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int wr_cnt, rd_cnt;

    line_buf_ctrl #(.IMG_WIDTH(W), .NUM_ROWS(R), .CNT_WIDTH(CW), .ROW_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_inc(fifo_wr_inc), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_inc(fifo_rd_inc), .fifo_wr_clr(fifo_wr_clr), .fifo_rd_clr(fifo_rd_clr),
        .out_valid(out_valid), .col_cnt(col_cnt), .row_cnt(row_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // external FIFO: read-before-write at the same address on one edge
    always @(posedge clk) begin
        if (fifo_wr_clr) wptr <= '0;
        else begin
            if (fifo_wr_en)  mem[wptr] <= pix_data;
            if (fifo_wr_inc) wptr <= wptr + 3'd1;
        end
        if (fifo_rd_clr) rptr <= '0;
        else begin
            if (fifo_rd_en)  dout <= mem[rptr];
            if (fifo_rd_inc) rptr <= rptr + 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        chk("clr_with_wr", {31'd0, fifo_wr_clr & fifo_wr_en}, 0);
        wr_cnt += int'(fifo_wr_en);
        rd_cnt += int'(fifo_rd_en);
        if (out_valid) begin
            if (exp_q.size() == 0) chk("sb_underflow", 0, 1);
            else chk("dout", {24'd0, dout}, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int base, input int gap, input int start_at, input int stop_at);
        start = 1'b1;
        #1;
        chk("idle_clr", {30'd0, fifo_wr_clr, fifo_rd_clr}, 3);
        chk("idle_busy", busy, 0);
        tick();
        start = 1'b0;
        chk("start_clr_drop", {30'd0, fifo_wr_clr, fifo_rd_clr}, 0);
        chk("fill_ready", pix_ready, 1);
        wr_cnt = 0;
        rd_cnt = 0;
        for (int p = 0; p < W * R; p++) begin
            int r, c;
            r = p / W;
            c = p % W;
            if (p == stop_at) return;
            if (gap != 0) begin
                pix_valid = 1'b0;
                #1;
                chk("gap_no_en", {28'd0, fifo_wr_en, fifo_wr_inc, fifo_rd_en, fifo_rd_inc}, 0);
                chk("gap_col", col_cnt, c);
                chk("gap_row", row_cnt, r);
                tick();
            end
            pix_valid = 1'b1;
            pix_data  = 8'(base + p + 1);
            start     = (p == start_at);
            #1;
            $display("pixel %0d row %0d col %0d wr_en=%0d rd_en=%0d", base + p + 1, row_cnt, col_cnt, fifo_wr_en, fifo_rd_en);
            chk("col", col_cnt, c);
            chk("row", row_cnt, r);
            chk("wr_en", fifo_wr_en, 1);
            chk("rd_en", fifo_rd_en, (r > 0) ? 1 : 0);
            if (r > 0) exp_q.push_back(base + p + 1 - W);
            tick();
            start = 1'b0;
            if (c == W - 1 && (r < R - 1 || FLUSH != 0)) begin
                chk("rowclr_clr", {30'd0, fifo_wr_clr, fifo_rd_clr}, 3);
                chk("rowclr_ready", pix_ready, 0);
                chk("rowclr_wr", fifo_wr_en, 0);
                tick();
                chk("after_clr", {30'd0, fifo_wr_clr, fifo_rd_clr}, 0);
            end
        end
        pix_valid = 1'b0;
        #1;
        for (int i = 0; i < W * FLUSH; i++) begin
            chk("flush_rd", fifo_rd_en, 1);
            chk("flush_wr", fifo_wr_en, 0);
            chk("flush_clr", {30'd0, fifo_wr_clr, fifo_rd_clr}, 0);
            exp_q.push_back(base + (R - 1) * W + i + 1);
            tick();
        end
        chk("done", done, 1);
        chk("done_clr", {30'd0, fifo_wr_clr, fifo_rd_clr}, 3);
        chk("wr_total", wr_cnt, W * R);
        chk("rd_total", rd_cnt, (R - 1) * W + W * FLUSH);
        tick();
        chk("done_pulse", done, 0);
        chk("busy_end", busy, 0);
        chk("row_end", row_cnt, 0);
        chk("q_empty", exp_q.size(), 0);
        $display("frame base %0d complete: wr=%0d rd=%0d", base, wr_cnt, rd_cnt);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        pix_data = 8'd0;
        wr_cnt = 0;
        rd_cnt = 0;
        tick();
        tick();
        chk("rst_clr", {30'd0, fifo_wr_clr, fifo_rd_clr}, 3);
        chk("rst_cnt", {col_cnt, row_cnt}, 0);
        chk("rst_flags", {28'd0, out_valid, done, busy, pix_ready}, 0);
        chk("rst_en", {28'd0, fifo_wr_en, fifo_wr_inc, fifo_rd_en, fifo_rd_inc}, 0);
        rst = 1'b0;
        tick();

        run_frame(0, 0, -1, -1);
        run_frame(20, 1, -1, -1);
        run_frame(40, 0, W + 2, -1);

        run_frame(60, 0, -1, W + 2);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_clr", {30'd0, fifo_wr_clr, fifo_rd_clr}, 3);
        chk("mid_rst_cnt", {col_cnt, row_cnt}, 0);
        chk("mid_rst_flags", {28'd0, out_valid, done, busy, pix_ready}, 0);
        exp_q.delete();
        pix_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_frame(100, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
- Single-clock sequencer for one FIFO_ASYNCH instance used as a one-row line delay in the convolution front end.
- Accepts a raster pixel stream and drives the FIFO's wr_en/wr_inc/rd_en/rd_inc/wr_clr/rd_clr, so each pixel read out is the pixel one row above the one being written.
- Re-clears both FIFO pointers at every row boundary, because FIFO pointers wrap at 2^ADD_WIDTH, not at the row length.

Parameters:
- IMG_WIDTH, 10, pixels per row; must be <= FIFO_SIZE and <= 2^ADD_WIDTH of the controlled FIFO.
- NUM_ROWS, 10, rows per frame; must be >= 2.
- CNT_WIDTH, 4, column counter width; must satisfy 2^CNT_WIDTH > IMG_WIDTH.
- ROW_WIDTH, 4, row counter width; must satisfy 2^ROW_WIDTH > NUM_ROWS.

Ports:
- clk  in  1  single clock; also drives the FIFO's clk1/clk2.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame start pulse; sampled only in IDLE.
- pix_valid  in  1  upstream pixel present.
- pix_ready  out  1  pixel accepted this cycle when pix_valid && pix_ready.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_wr_inc  out  1  to FIFO wr_inc.
- fifo_rd_en  out  1  to FIFO rd_en.
- fifo_rd_inc  out  1  to FIFO rd_inc.
- fifo_wr_clr  out  1  to FIFO wr_clr; registered.
- fifo_rd_clr  out  1  to FIFO rd_clr; registered.
- out_valid  out  1  FIFO data_out_fifo holds a valid delayed pixel this cycle.
- col_cnt  out  CNT_WIDTH  column of the next pixel to accept.
- row_cnt  out  ROW_WIDTH  row of the next pixel to accept.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- States: IDLE, FILL, STREAM, ROW_CLR, DONE (plus FLUSH when the optional feature is built).
- Reset values: state=IDLE, fifo_wr_clr=fifo_rd_clr=1, col_cnt=row_cnt=0, out_valid=0, done=0, busy=0, pix_ready=0, all FIFO enables 0.
- IDLE: both clears held at 1, so the FIFO stays cleared. On start=1: next state is FILL and both clears drop to 0 on that edge.
- accept = pix_valid && pix_ready. pix_ready = (state==FILL || state==STREAM), combinational.
- FILL (row 0):
  - fifo_wr_en = fifo_wr_inc = accept; fifo_rd_en = fifo_rd_inc = 0.
- STREAM (rows 1..NUM_ROWS-1):
  - fifo_wr_en = fifo_wr_inc = fifo_rd_en = fifo_rd_inc = accept.
  - The FIFO reads the old word and writes the new word at the same address on the same edge.
- col_cnt increments on accept. On the accept with col_cnt==IMG_WIDTH-1:
  - col_cnt <= 0 and row_cnt increments.
  - fifo_wr_clr and fifo_rd_clr are registered to 1 for exactly one cycle.
  - Next state is ROW_CLR, unless this was the last row (row_cnt==NUM_ROWS-1), in which case next state is DONE.
- ROW_CLR: one cycle; pix_ready=0; clears=1. Next state is STREAM (every row after a clear is a streaming row).
- DONE: one cycle; done=1; clears=1. Next state is IDLE; row_cnt <= 0.
- out_valid = fifo_rd_en delayed one clock (FIFO read latency is 1). FIFO output outside out_valid is don't-care (0 in practice).
- pix_valid low: no enables asserted; counters and state hold; no timeout.
- start outside IDLE is ignored.
- rst mid-frame: immediate return to reset values. The clears asserting at reset also empty the FIFO pointers.

Optional Feature:
- Macro LINE_BUF_CTRL_FLUSH_EN.
- Defined: after the last accept of the last row, go to FLUSH instead of DONE.
  - Asserting clears for the last-row boundary is still required in this path. In FLUSH (IMG_WIDTH cycles): fifo_rd_en=fifo_rd_inc=1, writes=0, pix_ready=0, clears=0.
  - This emits the final stored row, with out_valid following 1 cycle later. Then go to DONE.
- Undefined: the last row stays in the FIFO unread; no FLUSH state is synthesised.

Test Plan:
- IMG_WIDTH=4, NUM_ROWS=3, continuous pix_valid, pixels 1..12: fifo_wr_en high 12 cycles, fifo_rd_en high 8 cycles, ROW_CLR cycles after pixels 4 and 8. FIFO output sequence is 1,2,3,4,5,6,7,8 with out_valid, and done pulses once.
- Same frame with pix_valid low every other cycle: identical output order; counters frozen on idle cycles; no enables when pix_valid=0.
- Check fifo_wr_clr/fifo_rd_clr: 1 from reset until the edge after start; a 1-cycle pulse after col 3 of each row; never 1 coincident with fifo_wr_en.
- Assert start during STREAM at row 1, col 2: no effect; frame completes normally.
- Assert rst at row 1, col 2, then restart: outputs return to reset values, and the new frame's first read returns its own row 0 pixel 1.
- With LINE_BUF_CTRL_FLUSH_EN, same stimulus as the first scenario: 4 extra read cycles emit 9,10,11,12, then done; without the macro, done follows pixel 12 directly.
